// File: rtl/rf_pipe.sv
// rtl/rf_pipe.sv - pipelined register file with flags register, two registered read ports and optional write-to-read forwarding (RF_BYPASS_EN)
module rf_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             re_a,
  input  logic [AW-1:0]    ra_a,
  input  logic             re_b,
  input  logic [AW-1:0]    ra_b,
  input  logic             fwe,
  input  logic [WIDTH-1:0] fd,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  output logic             qa_vld,
  output logic             qb_vld,
  output logic [WIDTH-1:0] fo,
  output logic             err
);

  // Address DEPTH selects the flags register; anything above it is out of range.
  localparam logic [AW-1:0] FL_ADDR = AW'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] fl;
  logic             wr_ok;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             oob;

  // A write is accepted only for general registers or the flags register.
  assign wr_ok = we && (wa <= FL_ADDR);

  // Read mux: storage contents, with same-edge forwarding when bypass is built in.
  function automatic logic [WIDTH-1:0] rd_mux(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) v = regs[i];
    end
    if (addr == FL_ADDR) v = fl;
`ifdef RF_BYPASS_EN
    // wr_ok implies wa is in range, so out-of-range reads never forward.
    if (wr_ok && (wa == addr)) v = wd;
    else if ((addr == FL_ADDR) && fwe) v = fd;
`endif
    return v;
  endfunction

  // Combinational read data for both ports.
  always_comb begin
    rd_a = rd_mux(ra_a);
    rd_b = rd_mux(ra_b);
  end

  // Any enabled access above the flags address is an out-of-range event.
  assign oob = (we && (wa > FL_ADDR)) ||
               (re_a && (ra_a > FL_ADDR)) ||
               (re_b && (ra_b > FL_ADDR));

  // General register writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we && (wa == AW'(i))) regs[i] <= wd;
      end
    end
  end

  // Flags register: an explicit write beats the ALU update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fl <= '0;
    end else if (we && (wa == FL_ADDR)) begin
      fl <= wd;
    end else if (fwe) begin
      fl <= fd;
    end
  end

  // Port A registered read; data holds when not enabled, valid strobes per read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qa     <= '0;
      qa_vld <= 1'b0;
    end else begin
      if (re_a) qa <= rd_a;
      qa_vld <= re_a;
    end
  end

  // Port B registered read, independent of port A.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qb     <= '0;
      qb_vld <= 1'b0;
    end else begin
      if (re_b) qb <= rd_b;
      qb_vld <= re_b;
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (oob) begin
      err <= 1'b1;
    end
  end

  assign fo = fl;

endmodule
